instr_sequencer: RTL

//  Parametrised program store + issue sequencer that feeds instruction words to the processor's iin port.

---
 rtl/isa_pkg.sv | 24 ++
 rtl/prog_mem.sv | 37 +++
 rtl/instr_sequencer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/isa_pkg.sv
// Shared ISA and sequencer definitions: opcode values and FSM state encoding.
// Imported by the sequencer top and its program memory.
package isa_pkg;

    localparam int OPW = 3;

    localparam logic [OPW-1:0] OP_ADD  = 3'b000;
    localparam logic [OPW-1:0] OP_OUT  = 3'b100;
    localparam logic [OPW-1:0] OP_LDI  = 3'b101;
    localparam logic [OPW-1:0] OP_HALT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HALT  = 2'd3
    } seq_state_t;

    // Opcode field lives in the top three bits of an instruction word.
    function automatic logic [OPW-1:0] opcode_of(input logic [OPW-1:0] top_bits);
        return top_bits;
    endfunction

endpackage

// File: rtl/prog_mem.sv
// Program store: DEPTH x IW, one write port, registered read with write-first bypass.
// Latency: read data valid one cycle after address; no backpressure (always accepts writes).
// Backpressure: none; write gating is done by the caller.
module prog_mem
    import isa_pkg::*;
#(
    parameter  int IW    = 16,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [IW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [IW-1:0] rdata
);

    logic [IW-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // A word written in the same cycle it is read is returned directly, so a
    // program loaded alongside start is visible to the very first issue.
    always_ff @(posedge clock) begin
        if (we && (waddr == raddr)) begin
            rdata <= wdata;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Program store + issue sequencer driving the processor iin port, one instruction in flight.
// Latency: start -> iin_valid 2 cycles, done -> next iin_valid 2 cycles; waits indefinitely for done.
// Backpressure: holds iin until done; SEQ_LOOP_EN makes end-of-program wrap to pc 0 instead of halting.
module instr_sequencer
    import isa_pkg::*;
#(
    parameter  int IW    = 16,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [IW-1:0] wr_data,
    input  logic          start,
    input  logic [AW:0]   prog_len,
    input  logic          done,
    output logic [IW-1:0] iin,
    output logic          iin_valid,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          halted
);

`ifdef SEQ_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    seq_state_t    state;
    seq_state_t    state_nxt;
    logic [AW-1:0] pc_nxt;
    logic [AW:0]   prog_len_r;
    logic [IW-1:0] rd_data;

    logic          launch;
    logic          load_iin;
    logic          retire;
    logic          advance;
    logic          mem_we;
    logic          is_last;
    logic          is_halt_op;

    assign is_last    = ({1'b0, pc} == (prog_len_r - 1'b1));
    assign is_halt_op = (opcode_of(iin[IW-1 -: OPW]) == OP_HALT);

    // State register
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_nxt = (prog_len == '0) ? S_HALT : S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (done) begin
                    if (is_halt_op || (is_last && !LOOP_EN)) begin
                        state_nxt = S_HALT;
                    end else begin
                        state_nxt = S_ISSUE;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output / control decode
    always_comb begin
        busy     = (state == S_ISSUE) || (state == S_WAIT);
        halted   = (state == S_HALT);
        launch   = ((state == S_IDLE) || (state == S_HALT)) && start;
        load_iin = (state == S_ISSUE);
        retire   = (state == S_WAIT) && done;
        advance  = retire && (state_nxt == S_ISSUE);
        mem_we   = wr_en && !busy;
    end

    always_comb begin
        pc_nxt = pc;
        if (launch) begin
            pc_nxt = '0;
        end else if (advance) begin
            pc_nxt = is_last ? '0 : pc + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            pc         <= '0;
            prog_len_r <= '0;
            iin        <= '0;
            iin_valid  <= 1'b0;
        end else begin
            pc <= pc_nxt;
            if (launch) begin
                prog_len_r <= (prog_len > DEPTH_W) ? DEPTH_W : prog_len;
            end
            if (load_iin) begin
                iin       <= rd_data;
                iin_valid <= 1'b1;
            end else if (retire) begin
                iin_valid <= 1'b0;
            end
        end
    end

    // Read address tracks the upcoming pc so the word is ready in ISSUE.
    prog_mem #(
        .IW    (IW),
        .DEPTH (DEPTH)
    ) u_prog_mem (
        .clock (clock),
        .we    (mem_we),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (pc_nxt),
        .rdata (rd_data)
    );

endmodule
